uart_fifo_xfer_engine: RTL

Parametrised transfer engine between the UART RX FIFO read port and the UART TX FIFO write port. It paces reads from the RX FIFO and transforms each word with a run-time-selectable operation. It writes the result to the TX FIFO and stalls, never drops, while the TX FIFO is full. It replaces the fixed add-one loopback logic in the UART top level, all in the clk_out1 domain.

---
 rtl/uart_xfer_pkg.sv | 11 +
 rtl/uart_fifo_xfer_engine_if.sv | 21 ++
 rtl/uart_xfer_op.sv | 33 +++
 rtl/uart_fifo_xfer_engine.sv | 126 ++++++++++++
 4 files changed

// File: rtl/uart_xfer_pkg.sv
// Shared types for the UART FIFO transfer engine: FSM states and transform mode codes.
package uart_xfer_pkg;

    typedef enum logic [2:0] {IDLE, READ, WAIT, PROC, HOLD} xfer_state_t;

    localparam logic [1:0] MODE_PASS   = 2'd0;
    localparam logic [1:0] MODE_ADD    = 2'd1;
    localparam logic [1:0] MODE_XOR    = 2'd2;
    localparam logic [1:0] MODE_BITREV = 2'd3;

endpackage

// File: rtl/uart_fifo_xfer_engine_if.sv
// FIFO-side bundle of the transfer engine: RX FIFO read port and TX FIFO write port.
interface uart_fifo_xfer_engine_if #(
    parameter int DATA_W = 8
);
    logic              rx_empty;
    logic [DATA_W-1:0] rx_dout;
    logic              rx_rd_en;
    logic              tx_full;
    logic              tx_wr_en;
    logic [DATA_W-1:0] tx_din;

    modport master (
        input  rx_empty, rx_dout, tx_full,
        output rx_rd_en, tx_wr_en, tx_din
    );

    modport slave (
        output rx_empty, rx_dout, tx_full,
        input  rx_rd_en, tx_wr_en, tx_din
    );
endinterface

// File: rtl/uart_xfer_op.sv
// Combinational word transform applied to each RX word before it is written to the TX FIFO.
module uart_xfer_op
    import uart_xfer_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADD_VAL  = 1,
    parameter logic [DATA_W-1:0] XOR_MASK = DATA_W'(8'hFF)
) (
    input  logic [DATA_W-1:0] d,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] result
);
    localparam logic [DATA_W-1:0] ADD_C = DATA_W'(ADD_VAL);

    logic [DATA_W-1:0] rev;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_rev
            assign rev[gi] = d[DATA_W-1-gi];
        end
    endgenerate

    always_comb begin
        result = d;
        case (mode)
            MODE_ADD:    result = d + ADD_C;
            MODE_XOR:    result = d ^ XOR_MASK;
            MODE_BITREV: result = rev;
            default:     result = d;
        endcase
    end
endmodule

// File: rtl/uart_fifo_xfer_engine.sv
// Paced RX FIFO -> transform -> TX FIFO transfer engine; stalls while the TX FIFO is full.
// Optional word counters are built when XFER_STATS_EN is defined.
module uart_fifo_xfer_engine
    import uart_xfer_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                RD_LAT   = 1,
    parameter int                RD_GAP   = 6,
    parameter int                ADD_VAL  = 1,
    parameter logic [DATA_W-1:0] XOR_MASK = DATA_W'(8'hFF),
    parameter int                CNT_W    = 16
) (
    input  logic                  clk_out1,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    uart_fifo_xfer_engine_if.master fifo,
    output logic                  busy,
    output logic [CNT_W-1:0]      rx_cnt,
    output logic [CNT_W-1:0]      tx_cnt
);
    localparam int GAP_W  = $clog2(RD_GAP + 1);
    localparam int WAIT_W = $clog2(RD_LAT + 1);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(RD_GAP);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

    xfer_state_t       state_reg, state_next;
    logic [GAP_W-1:0]  gap_reg, gap_next, gap_inc;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [DATA_W-1:0] result_reg, result_next, op_result;
    logic              rd_en_reg;
    logic              busy_reg;
    logic              wr_fire;

    uart_xfer_op #(
        .DATA_W   (DATA_W),
        .ADD_VAL  (ADD_VAL),
        .XOR_MASK (XOR_MASK)
    ) u_op (
        .d      (fifo.rx_dout),
        .mode   (mode),
        .result (op_result)
    );

    always_comb begin
        state_next  = state_reg;
        gap_next    = gap_reg;
        wait_next   = wait_reg;
        result_next = result_reg;
        wr_fire     = 1'b0;
        gap_inc     = (gap_reg == GAP_MAX) ? gap_reg : gap_reg + 1'b1;
        case (state_reg)
            IDLE: begin
                gap_next = gap_inc;
                // Deciding on the incremented count keeps the word period at 1+RD_LAT+1+RD_GAP.
                if (gap_inc == GAP_MAX && enable && !fifo.rx_empty)
                    state_next = READ;
            end
            READ: begin
                wait_next  = '0;
                state_next = WAIT;
            end
            WAIT: begin
                wait_next = wait_reg + 1'b1;
                if (wait_reg == WAIT_LAST) begin
                    result_next = op_result;
                    state_next  = PROC;
                end
            end
            PROC, HOLD: begin
                // tx_full is used in the write cycle itself so a full FIFO never sees a strobe.
                if (!fifo.tx_full) begin
                    wr_fire    = 1'b1;
                    gap_next   = '0;
                    state_next = IDLE;
                end else begin
                    state_next = HOLD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_out1) begin
        if (rst) begin
            state_reg  <= IDLE;
            gap_reg    <= '0;
            wait_reg   <= '0;
            result_reg <= '0;
            rd_en_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            gap_reg    <= gap_next;
            wait_reg   <= wait_next;
            result_reg <= result_next;
            rd_en_reg  <= (state_next == READ);
            busy_reg   <= (state_next != IDLE);
        end
    end

    assign fifo.rx_rd_en = rd_en_reg;
    assign fifo.tx_wr_en = wr_fire;
    assign fifo.tx_din   = result_reg;
    assign busy          = busy_reg;

`ifdef XFER_STATS_EN
    logic [CNT_W-1:0] rx_cnt_reg, tx_cnt_reg;

    always_ff @(posedge clk_out1) begin
        if (rst) begin
            rx_cnt_reg <= '0;
            tx_cnt_reg <= '0;
        end else begin
            if (rd_en_reg) rx_cnt_reg <= rx_cnt_reg + 1'b1;
            if (wr_fire)   tx_cnt_reg <= tx_cnt_reg + 1'b1;
        end
    end

    assign rx_cnt = rx_cnt_reg;
    assign tx_cnt = tx_cnt_reg;
`else
    assign rx_cnt = '0;
    assign tx_cnt = '0;
`endif
endmodule
